aio_load_chram_ext: RTL
=======================

AIO_LOAD_CHRAM_EXT -- requirements
Module: aio_load_chram_ext

Interface
REQ-001 SHALL have parameters: EEP_BASE, default 16'h0800, EEPROM address of region 0.
REQ-002 SHALL have parameters: EEP_STRIDE, default 16'h1100, EEPROM offset between regions.
REQ-003 SHALL have parameters: PARA_LEN, default 17'h1100, bytes per region; SHALL be even.
REQ-004 SHALL have parameters: RAM_AW, default 12, chram address width.
REQ-005 SHALL have parameters: RAM_STRIDE, default 0, chram base offset between regions.
REQ-006 SHALL have parameters: CHK_EN, default 1, enables checksum checking.
REQ-007 SHALL have parameters: TIMEOUT_CYC, default 4096, idle cycles between bytes before abort.
REQ-008 SHALL have ports, with clock and reset first:
- sys_clk  in  1  single clock.
- glbl_rst  in  1  asynchronous, active-high reset.
- load_chram_en  in  1  start/hold level.
- region_sel  in  2  region, sampled at start.
- load_chram_done  out  1  one-cycle success pulse.
- load_chram_error  out  1  one-cycle failure pulse.
- err_code  out  3  failure cause, held until next start.
- words_loaded  out  RAM_AW+1  chram writes in the current or last load.
- chram_eep_rden  out  1  EEPROM read request (level).
- chram_eep_length  out  17  byte count.
- chram_eep_addr  out  16  start address.
- init_eep_valid  in  1  byte strobe.
- init_eep_last  in  1  final byte, qualified by valid.
- init_eep_data  in  8  byte.
- init_chram_wren  out  1  write pulse.
- init_chram_addr  out  RAM_AW  write address.
- init_chram_wdata  out  8  write data.

Function
REQ-009 SHALL implement FSM states IDLE, DATA, CHK, DONE, ERR.
REQ-010 SHALL leave IDLE only on a rising edge of load_chram_en; a held-high level SHALL NOT restart the block after DONE or ERR.
REQ-011 On start: SHALL latch region_sel; SHALL clear err_code and words_loaded; SHALL drive chram_eep_addr = EEP_BASE + region_sel*EEP_STRIDE (16-bit wrap) and chram_eep_length = PARA_LEN; SHALL assert chram_eep_rden from the next cycle until the block leaves DATA/CHK; SHALL enter DATA.
REQ-012 The byte stream SHALL be pairs: a data byte (DATA) followed by a check byte (CHK); a valid in DATA SHALL latch the data byte and move to CHK.
REQ-013 A valid in CHK SHALL pass if CHK_EN=0, or if check[7:4] equals the popcount (0..8) of the latched data byte; check[3:0] SHALL be ignored.
REQ-014 On pass: the next cycle SHALL pulse init_chram_wren for exactly 1 cycle with wdata = the latched byte and addr = region_sel*RAM_STRIDE + words_loaded, modulo 2^RAM_AW; words_loaded SHALL increment.
REQ-015 A failed pair SHALL never be written to chram.
REQ-016 Pass with last=1 in CHK SHALL go to DONE; DONE SHALL pulse load_chram_done for 1 cycle, then return to IDLE.
REQ-017 Error causes SHALL go to ERR (pulse load_chram_error for 1 cycle, latch err_code, drop rden, then IDLE):
- 1 = checksum mismatch.
- 2 = timeout: TIMEOUT_CYC consecutive cycles in DATA/CHK without valid; the counter SHALL reset on every valid.
- 3 = last asserted on a data byte.
- 4 = overflow: a pass when words_loaded already equals PARA_LEN/2 without last.
- 5 = load_chram_en low while in DATA/CHK.
REQ-018 Simultaneous events SHALL be resolved with priority abort(5) > checksum(1) > overflow(4) > odd-last(3) > timeout(2).
REQ-019 init_eep_valid SHALL be ignored in IDLE, DONE and ERR.

Reset
REQ-020 glbl_rst SHALL asynchronously force IDLE and drive every output and internal register to 0, including mid-load; no write pulse SHALL be emitted after reset asserts.

Structure
REQ-021 A shared package SHALL hold the state encodings, the err_code constants (0..5) and the default addresses and lengths.
REQ-022 A sub-module aio_chk_popcnt (8-bit to 4-bit combinational popcount) SHALL be used.
REQ-023 The timeout counter width SHALL be clog2(TIMEOUT_CYC+1).

Verification
REQ-024 region 0 start, 8 good pairs 0x00/0x00, 0xFF/0x80, ... with last on the 8th check byte -> rden=1, addr 0x0800, len 0x1100, 8 wren pulses at addr 0..7, done pulse, err_code=0.
REQ-025 region 1, data 0x0F with check 0x30 -> error pulse, err_code=1, no wren for that pair, rden drops.
REQ-026 input stalls for 4096 cycles after the 3rd pair -> err_code=2, words_loaded=3.
REQ-027 last on a data byte -> err_code=3; en held high afterward -> no restart until en toggles.
REQ-028 glbl_rst asserted mid-CHK -> all outputs 0 immediately; CHK_EN=0 rerun with bad checks -> all pairs written, done pulse.

Source files
------------

// File: rtl/aio_load_chram_ext_pkg.sv
// Shared types and defaults for the AIO channel-RAM loader.
// State encoding, error causes and the default EEPROM layout.
package aio_load_chram_ext_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_CHK   = 3'd1;
  localparam logic [2:0] ERR_TMO   = 3'd2;
  localparam logic [2:0] ERR_ODD   = 3'd3;
  localparam logic [2:0] ERR_OVF   = 3'd4;
  localparam logic [2:0] ERR_ABORT = 3'd5;

  localparam logic [15:0] DEF_EEP_BASE    = 16'h0800;
  localparam logic [15:0] DEF_EEP_STRIDE  = 16'h1100;
  localparam logic [16:0] DEF_PARA_LEN    = 17'h1100;
  localparam int          DEF_RAM_AW      = 12;
  localparam int          DEF_TIMEOUT_CYC = 4096;

  function automatic logic [15:0] eep_region_addr(
    input logic [15:0] base,
    input logic [15:0] stride,
    input logic [1:0]  region
  );
    return base + stride * {14'd0, region};
  endfunction

endpackage

// File: rtl/aio_load_chram_ext_popcnt.sv
// Byte popcount used to validate the check nibble.
// Purely combinational, result 0..8.
module aio_chk_popcnt (
  input  logic [7:0] din,
  output logic [3:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'd0, din[i]};
    end
  end

endmodule

// File: rtl/aio_load_chram_ext.sv
// AIO channel-RAM loader: streams data/check byte pairs from EEPROM
// and writes the verified data bytes into chram.
module aio_load_chram_ext
  import aio_load_chram_ext_pkg::*;
#(
  parameter logic [15:0] EEP_BASE    = DEF_EEP_BASE,
  parameter logic [15:0] EEP_STRIDE  = DEF_EEP_STRIDE,
  parameter logic [16:0] PARA_LEN    = DEF_PARA_LEN,
  parameter int          RAM_AW      = DEF_RAM_AW,
  parameter int          RAM_STRIDE  = 0,
  parameter bit          CHK_EN      = 1'b1,
  parameter int          TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              sys_clk,
  input  logic              glbl_rst,
  input  logic              load_chram_en,
  input  logic [1:0]        region_sel,
  output logic              load_chram_done,
  output logic              load_chram_error,
  output logic [2:0]        err_code,
  output logic [RAM_AW:0]   words_loaded,
  output logic              chram_eep_rden,
  output logic [16:0]       chram_eep_length,
  output logic [15:0]       chram_eep_addr,
  input  logic              init_eep_valid,
  input  logic              init_eep_last,
  input  logic [7:0]        init_eep_data,
  output logic              init_chram_wren,
  output logic [RAM_AW-1:0] init_chram_addr,
  output logic [7:0]        init_chram_wdata
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int WB = RAM_AW + 1;
  localparam logic [TW-1:0]     TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [WB-1:0]     MAX_WORDS = WB'(PARA_LEN >> 1);
  localparam logic [RAM_AW-1:0] STRIDE_W  = RAM_AW'(RAM_STRIDE);

  state_t state_q, state_d;

  logic              en_q;
  logic [1:0]        region_q;
  logic [7:0]        data_q;
  logic [TW-1:0]     tmo_q;
  logic [WB-1:0]     words_q;
  logic [2:0]        err_q, err_d;
  logic [15:0]       eep_addr_q;
  logic [16:0]       eep_len_q;
  logic              wren_q;
  logic [RAM_AW-1:0] waddr_q;
  logic [7:0]        wdata_q;

  logic              start;
  logic              take_data;
  logic              wr;
  logic              busy;
  logic              tmo_hit;
  logic              chk_ok;
  logic [3:0]        pop_cnt;
  logic [RAM_AW-1:0] ram_base;

  aio_chk_popcnt u_popcnt (
    .din (data_q),
    .cnt (pop_cnt)
  );

  assign busy     = (state_q == ST_DATA) || (state_q == ST_CHK);
  assign tmo_hit  = !init_eep_valid && (tmo_q == TMO_LAST);
  assign chk_ok   = !CHK_EN || (init_eep_data[7:4] == pop_cnt);
  assign ram_base = STRIDE_W * RAM_AW'(region_q);

  always_ff @(posedge sys_clk or posedge glbl_rst) begin
    if (glbl_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Abort outranks everything; within CHK the byte verdict outranks timeout.
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    start     = 1'b0;
    take_data = 1'b0;
    wr        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (load_chram_en && !en_q) begin
          start   = 1'b1;
          err_d   = ERR_NONE;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (!load_chram_en) begin
          err_d   = ERR_ABORT;
          state_d = ST_ERR;
        end else if (init_eep_valid && init_eep_last) begin
          err_d   = ERR_ODD;
          state_d = ST_ERR;
        end else if (init_eep_valid) begin
          take_data = 1'b1;
          state_d   = ST_CHK;
        end else if (tmo_hit) begin
          err_d   = ERR_TMO;
          state_d = ST_ERR;
        end
      end
      ST_CHK: begin
        if (!load_chram_en) begin
          err_d   = ERR_ABORT;
          state_d = ST_ERR;
        end else if (init_eep_valid && !chk_ok) begin
          err_d   = ERR_CHK;
          state_d = ST_ERR;
        end else if (init_eep_valid && !init_eep_last
                     && words_q == MAX_WORDS) begin
          err_d   = ERR_OVF;
          state_d = ST_ERR;
        end else if (init_eep_valid) begin
          wr      = 1'b1;
          state_d = init_eep_last ? ST_DONE : ST_DATA;
        end else if (tmo_hit) begin
          err_d   = ERR_TMO;
          state_d = ST_ERR;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge glbl_rst) begin
    if (glbl_rst) begin
      en_q       <= 1'b0;
      region_q   <= '0;
      data_q     <= '0;
      tmo_q      <= '0;
      words_q    <= '0;
      err_q      <= ERR_NONE;
      eep_addr_q <= '0;
      eep_len_q  <= '0;
      wren_q     <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      en_q   <= load_chram_en;
      err_q  <= err_d;
      wren_q <= wr;
      if (start) begin
        region_q   <= region_sel;
        words_q    <= '0;
        eep_addr_q <= eep_region_addr(EEP_BASE, EEP_STRIDE, region_sel);
        eep_len_q  <= PARA_LEN;
      end
      if (take_data) begin
        data_q <= init_eep_data;
      end
      if (start || !busy || init_eep_valid) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + 1'b1;
      end
      if (wr) begin
        waddr_q <= ram_base + words_q[RAM_AW-1:0];
        wdata_q <= data_q;
        words_q <= words_q + 1'b1;
      end
    end
  end

  assign load_chram_done  = (state_q == ST_DONE);
  assign load_chram_error = (state_q == ST_ERR);
  assign err_code         = err_q;
  assign words_loaded     = words_q;
  assign chram_eep_rden   = busy;
  assign chram_eep_length = eep_len_q;
  assign chram_eep_addr   = eep_addr_q;
  assign init_chram_wren  = wren_q;
  assign init_chram_addr  = waddr_q;
  assign init_chram_wdata = wdata_q;

endmodule
